// File: rtl/unified_mem_arbiter.sv
// Single-port unified memory arbiter for the IF and MEM stages.
// Handles fetch stalls, starvation limiting, store lane steering and load extension.
module unified_mem_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    output logic        stall_if,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t          state, next;
    logic            port_q;
    logic            we_q;
    logic            err_q;
    logic [3:0]      be_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [1:0]      off_q;
    logic [2:0]      f3_q;
    logic [LW-1:0]   lat_q;
    logic [SW-1:0]   starve_q;
    logic [31:0]     if_rdata_q;
    logic [31:0]     d_rdata_q;
    logic            grant_d;
    logic            grant_i;
    logic            legal;
    logic            last;
    logic [3:0]      be_d;
    logic [31:0]     wdata_d;
    logic            unused_bits;

    assign unused_bits = ^if_addr[1:0];

    function automatic logic [31:0] extend(input logic [31:0] w,
                                           input logic [2:0]  f3,
                                           input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  extend = {{24{b[7]}}, b};
            3'b100:  extend = {24'b0, b};
            3'b001:  extend = {{16{h[15]}}, h};
            3'b101:  extend = {16'b0, h};
            default: extend = w;
        endcase
    endfunction

    always_comb begin
        grant_d = (state == IDLE) && d_req &&
                  ((starve_q < SW'(STARVE_MAX)) || !if_req);
        grant_i = (state == IDLE) && !grant_d && if_req;
        last    = (lat_q == LW'(MEM_LAT - 1));
    end

    always_comb begin
        legal = 1'b0;
        case (d_funct3)
            3'b000, 3'b100: legal = 1'b1;
            3'b001, 3'b101: legal = !d_addr[0];
            3'b010:         legal = (d_addr[1:0] == 2'b00);
            default:        legal = 1'b0;
        endcase
        if (d_we && d_funct3[2])
            legal = 1'b0;
    end

    // Stores steer lanes by size; loads always read the whole word.
    always_comb begin
        be_d    = 4'hF;
        wdata_d = d_wdata;
        if (d_we) begin
            case (d_funct3[1:0])
                2'b00: begin
                    be_d    = 4'b0001 << d_addr[1:0];
                    wdata_d = {4{d_wdata[7:0]}};
                end
                2'b01: begin
                    be_d    = 4'b0011 << d_addr[1:0];
                    wdata_d = {2{d_wdata[15:0]}};
                end
                default: begin
                    be_d    = 4'hF;
                    wdata_d = d_wdata;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE: begin
                if (grant_d)
                    next = legal ? ACCESS : RESP;
                else if (grant_i)
                    next = ACCESS;
            end
            ACCESS: if (last) next = RESP;
            RESP:   next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            port_q     <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            be_q       <= 4'h0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            off_q      <= 2'b00;
            f3_q       <= 3'b000;
            lat_q      <= '0;
            starve_q   <= '0;
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 32'h0;
        end else begin
            if (grant_d) begin
                port_q  <= 1'b1;
                we_q    <= d_we;
                err_q   <= !legal;
                be_q    <= be_d;
                addr_q  <= {d_addr[31:2], 2'b00};
                wdata_q <= wdata_d;
                off_q   <= d_addr[1:0];
                f3_q    <= d_funct3;
                lat_q   <= '0;
                if (!if_req)
                    starve_q <= '0;
                else if (starve_q < SW'(STARVE_MAX))
                    starve_q <= starve_q + 1'b1;
            end else if (grant_i) begin
                port_q   <= 1'b0;
                we_q     <= 1'b0;
                err_q    <= 1'b0;
                be_q     <= 4'hF;
                addr_q   <= {if_addr[31:2], 2'b00};
                lat_q    <= '0;
                starve_q <= '0;
            end
            if (state == ACCESS) begin
                if (!last)
                    lat_q <= lat_q + 1'b1;
                else if (!port_q)
                    if_rdata_q <= mem_rdata;
                else if (!we_q)
                    d_rdata_q <= extend(mem_rdata, f3_q, off_q);
            end
        end
    end

    always_comb begin
        mem_en    = (state == ACCESS);
        mem_we    = mem_en && we_q;
        mem_be    = mem_en ? be_q : 4'h0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if_ack    = (state == RESP) && !port_q;
        d_ack     = (state == RESP) && port_q;
        d_err     = d_ack && err_q;
        stall_if  = if_req && !if_ack;
        if_rdata  = if_rdata_q;
        d_rdata   = d_rdata_q;
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed scoreboard bench for unified_mem_arbiter.
// Uses a MEM_LAT=1 instance for most steps and a MEM_LAT=3 one for mid-access reset.
module tb_unified_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        d_req = 1'b0;
    logic        d_req3 = 1'b0;
    logic        d_we = 1'b0;
    logic [2:0]  d_funct3 = 3'b000;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;

    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ack, stall_if, d_ack, d_err, mem_en, mem_we;
    logic [3:0]  mem_be;

    logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
    logic        if_ack3, stall_if3, d_ack3, d_err3, mem_en3, mem_we3;
    logic [3:0]  mem_be3;

    logic [31:0] mem [0:255];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } dexp_t;

    dexp_t       dq[$];
    logic [31:0] fq[$];
    logic        pq[$];
    int          n_cmp = 0;
    int          n_mis = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(2)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ack(if_ack), .stall_if(stall_if),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .d_ack(d_ack), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    unified_mem_arbiter #(.MEM_LAT(3), .STARVE_MAX(2)) u_dut3 (
        .clk(clk), .rst(rst),
        .if_req(1'b0), .if_addr(if_addr), .if_rdata(if_rdata3),
        .if_ack(if_ack3), .stall_if(stall_if3),
        .d_req(d_req3), .d_we(d_we), .d_funct3(d_funct3),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata3),
        .d_ack(d_ack3), .d_err(d_err3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_be(mem_be3),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
    );

    assign mem_rdata  = mem[mem_addr[9:2]];
    assign mem_rdata3 = mem[mem_addr3[9:2]];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[4]  <= 32'h00A0_0093;
            mem[64] <= 32'h80FF_1234;
        end else if (mem_en && mem_we) begin
            for (int i = 0; i < 4; i++)
                if (mem_be[i])
                    mem[mem_addr[9:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic do_fetch(input string tag, input logic [31:0] a,
                            input logic [31:0] exp);
        int          cyc = 0;
        int          en = 0;
        bit          done = 0;
        logic [31:0] ad_s = 32'h0;
        logic [3:0]  be_s = 4'h0;
        logic [31:0] e;
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = a;
        fq.push_back(exp);
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (mem_en) begin
                en++;
                ad_s = mem_addr;
                be_s = mem_be;
                chk({tag, "_stall_wait"}, 32'(stall_if), 32'd1);
            end
            if (if_ack) begin
                done = 1;
                chk({tag, "_stall_ack"}, 32'(stall_if), 32'd0);
                if_req = 1'b0;
                e = fq.pop_front();
                chk({tag, "_rdata"}, if_rdata, e);
                chk({tag, "_lat"}, cyc, 32'd2);
                chk({tag, "_en_cycles"}, en, 32'd1);
                chk({tag, "_addr"}, ad_s, {a[31:2], 2'b00});
                chk({tag, "_be"}, 32'(be_s), 32'hF);
            end
        end
        if (!done) begin
            if_req = 1'b0;
            chk({tag, "_timeout"}, 32'(done), 32'd1);
        end
    endtask

    task automatic do_data(input string tag, input logic we,
                           input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] exp_rd,
                           input logic exp_err, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd, input int exp_lat,
                           input int exp_en);
        int          cyc = 0;
        int          en = 0;
        bit          done = 0;
        logic [31:0] ad_s = 32'h0;
        logic [31:0] wd_s = 32'h0;
        logic [3:0]  be_s = 4'h0;
        logic        we_s = 1'b0;
        dexp_t       e;
        @(negedge clk);
        d_req    = 1'b1;
        d_we     = we;
        d_funct3 = f3;
        d_addr   = a;
        d_wdata  = wd;
        dq.push_back('{rdata: exp_rd, err: exp_err});
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (mem_en) begin
                en++;
                ad_s = mem_addr;
                wd_s = mem_wdata;
                be_s = mem_be;
                we_s = mem_we;
            end
            if (d_ack) begin
                done = 1;
                d_req = 1'b0;
                e = dq.pop_front();
                chk({tag, "_rdata"}, d_rdata, e.rdata);
                chk({tag, "_err"}, 32'(d_err), 32'(e.err));
                chk({tag, "_lat"}, cyc, exp_lat);
                chk({tag, "_en_cycles"}, en, exp_en);
                if (en > 0) begin
                    chk({tag, "_addr"}, ad_s, {a[31:2], 2'b00});
                    chk({tag, "_be"}, 32'(be_s), 32'(exp_be));
                    chk({tag, "_we"}, 32'(we_s), 32'(we));
                    if (we)
                        chk({tag, "_wdata"}, wd_s, exp_wd);
                end
            end
        end
        if (!done) begin
            d_req = 1'b0;
            chk({tag, "_timeout"}, 32'(done), 32'd1);
        end
    endtask

    initial begin
        int  acks;
        int  cyc;
        bit  done;
        dexp_t e;

        #1 rst = 1'b0;
        #2;
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
        chk("rst_err", 32'(d_err), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_stall", 32'(stall_if), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        do_fetch("fetch10", 32'h0000_0010, 32'h00A0_0093);

        do_data("lb", 1'b0, 3'b000, 32'h103, 32'h0, 32'hFFFF_FF80,
                1'b0, 4'hF, 32'h0, 2, 1);
        do_data("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h0000_0080,
                1'b0, 4'hF, 32'h0, 2, 1);
        do_data("sh", 1'b1, 3'b001, 32'h102, 32'h0000_BEEF, 32'h0000_0080,
                1'b0, 4'b1100, 32'hBEEF_BEEF, 2, 1);
        do_data("lw", 1'b0, 3'b010, 32'h100, 32'h0, 32'hBEEF_1234,
                1'b0, 4'hF, 32'h0, 2, 1);
        do_data("lh", 1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFF_BEEF,
                1'b0, 4'hF, 32'h0, 2, 1);
        do_data("sb", 1'b1, 3'b000, 32'h101, 32'h0000_005A, 32'hFFFF_BEEF,
                1'b0, 4'b0010, 32'h5A5A_5A5A, 2, 1);
        do_data("lbu_sb", 1'b0, 3'b100, 32'h101, 32'h0, 32'h0000_005A,
                1'b0, 4'hF, 32'h0, 2, 1);
        do_data("lw_mis", 1'b0, 3'b010, 32'h201, 32'h0, 32'h0000_005A,
                1'b1, 4'hF, 32'h0, 1, 0);
        do_data("lh_mis", 1'b0, 3'b001, 32'h101, 32'h0, 32'h0000_005A,
                1'b1, 4'hF, 32'h0, 1, 0);
        do_data("st_f3", 1'b1, 3'b100, 32'h100, 32'h1, 32'h0000_005A,
                1'b1, 4'hF, 32'h0, 1, 0);

        // Both requesters held high: data, data, fetch, repeated.
        pq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        @(negedge clk);
        d_we     = 1'b0;
        d_funct3 = 3'b010;
        d_addr   = 32'h100;
        if_addr  = 32'h10;
        d_req    = 1'b1;
        if_req   = 1'b1;
        acks = 0;
        cyc  = 0;
        while (acks < 6 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (d_ack || if_ack) begin
                chk($sformatf("starve_order%0d", acks), 32'(d_ack),
                    32'(pq.pop_front()));
                acks++;
            end
        end
        d_req  = 1'b0;
        if_req = 1'b0;
        chk("starve_acks", acks, 32'd6);

        // Reset during the second ACCESS cycle of the MEM_LAT=3 instance.
        repeat (2) @(negedge clk);
        d_funct3 = 3'b010;
        d_addr   = 32'h10;
        d_we     = 1'b0;
        d_req3   = 1'b1;
        dq.push_back('{rdata: 32'h00A0_0093, err: 1'b0});
        @(posedge clk);
        @(negedge clk);
        chk("l3_en_first", 32'(mem_en3), 32'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("l3_rst_en", 32'(mem_en3), 32'd0);
        chk("l3_rst_be", 32'(mem_be3), 32'd0);
        chk("l3_rst_ack", 32'(d_ack3), 32'd0);
        chk("l3_rst_rdata", d_rdata3, 32'h0);
        chk("rst2_if_rdata", if_rdata, 32'h0);
        chk("rst2_d_rdata", d_rdata, 32'h0);
        @(negedge clk);
        rst  = 1'b1;
        cyc  = 0;
        done = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (d_ack3) begin
                done = 1;
                d_req3 = 1'b0;
                e = dq.pop_front();
                chk("l3_rdata", d_rdata3, e.rdata);
                chk("l3_err", 32'(d_err3), 32'(e.err));
                chk("l3_lat", cyc, 32'd4);
            end
        end
        d_req3 = 1'b0;
        if (!done)
            chk("l3_timeout", 32'(done), 32'd1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
